// File: rtl/cpu_defs.sv
// Shared CPU definitions: ALU function codes, ALUOp codes, funct values,
// forward-select encoding and the ALU control decode helper.
// Pure declarations; no timing, no flow control.
package cpu_defs;

  // ALU function codes driven on alu_signal
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOp codes from the main decoder (2'b11 is unused and flagged illegal)
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // R-type funct values understood by the ALU
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Operand source select for the forwarding muxes
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [2:0] sig;
    logic       illegal;
  } alu_dec_t;

  // Unsupported encodings fall back to ADD so the ALU still sees a legal code
  function automatic alu_dec_t alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    alu_dec_t d;
    d.sig     = ALU_ADD;
    d.illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: d.sig = ALU_ADD;
      ALUOP_SUB: d.sig = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: d.sig = ALU_ADD;
          FUNCT_SUB: d.sig = ALU_SUB;
          FUNCT_AND: d.sig = ALU_AND;
          FUNCT_OR:  d.sig = ALU_OR;
          FUNCT_SLT: d.sig = ALU_SLT;
          default:   d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select: picks EX/MEM, MEM/WB or register-file data per ALU source.
// Latency: purely combinational.
// Backpressure: none; selects follow the current pipeline contents.
import cpu_defs::*;

module fwd_unit #(
  parameter int RW = 5
) (
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [RW-1:0] ex_rs,
  input  logic [RW-1:0] ex_rt,
  output fwd_sel_t      fwd_a,
  output fwd_sel_t      fwd_b
);

  // Youngest producer wins; register 0 is hardwired zero and never forwards
  function automatic fwd_sel_t pick(input logic [RW-1:0] idx,
                                    input logic ex_w, input logic [RW-1:0] ex_d,
                                    input logic wb_w, input logic [RW-1:0] wb_d);
    fwd_sel_t s;
    s = FWD_REG;
    if (ex_w && (ex_d != '0) && (ex_d == idx))
      s = FWD_EXMEM;
    else if (wb_w && (wb_d != '0) && (wb_d == idx))
      s = FWD_MEMWB;
    return s;
  endfunction

  // Independent select for each ALU source
  always_comb begin
    fwd_a = pick(ex_rs, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
    fwd_b = pick(ex_rt, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, operand forwarding and load-use detect.
// Latency: 1 cycle from id_* inputs to ex_* / alu_signal; ALU operands add combinational forwarding.
// Backpressure: stall holds every register; flush (wins over stall) loads a bubble.
import cpu_defs::*;

module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [15:0]   id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [1:0]    id_aluop,
  input  logic [5:0]    id_funct,
  input  logic          id_alusrc,
  input  logic          id_regdst,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_dataA,
  output logic [DW-1:0] alu_dataB,
  output logic [2:0]    alu_signal,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          ex_illegal,
  output logic          load_use_hazard
);

  logic [DW-1:0] ex_rs_data;
  logic [DW-1:0] ex_rt_data;
  logic [DW-1:0] ex_imm;
  logic [RW-1:0] ex_rs;
  logic [RW-1:0] ex_rt;
  logic          ex_alusrc;
  alu_dec_t      dec;
  fwd_sel_t      fwd_a;
  fwd_sel_t      fwd_b;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;

  // ALU control is decoded in ID so alu_signal comes straight from a flop
  always_comb dec = alu_decode(id_aluop, id_funct);

  // Pipeline register: reset and flush both load an all-zero bubble
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_dest     <= '0;
      ex_alusrc   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_illegal  <= 1'b0;
      alu_signal  <= ALU_AND;
    end else if (!stall) begin
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm      <= {{(DW-16){id_imm[15]}}, id_imm};
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_dest     <= id_regdst ? id_rd : id_rt;
      ex_alusrc   <= id_alusrc;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
      ex_memwrite <= id_memwrite;
      ex_memtoreg <= id_memtoreg;
      ex_illegal  <= dec.illegal;
      alu_signal  <= dec.sig;
    end
  end

  fwd_unit #(.RW(RW)) u_fwd (
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );

  // Forwarding muxes for both sources
  always_comb begin
    rs_fwd = ex_rs_data;
    rt_fwd = ex_rt_data;
    case (fwd_a)
      FWD_EXMEM: rs_fwd = exmem_result;
      FWD_MEMWB: rs_fwd = memwb_result;
      default:   rs_fwd = ex_rs_data;
    endcase
    case (fwd_b)
      FWD_EXMEM: rt_fwd = exmem_result;
      FWD_MEMWB: rt_fwd = memwb_result;
      default:   rt_fwd = ex_rt_data;
    endcase
  end

  // Operand B takes the immediate for I-type; stores always need the forwarded rt
  always_comb begin
    alu_dataA     = rs_fwd;
    alu_dataB     = ex_alusrc ? ex_imm : rt_fwd;
    ex_store_data = rt_fwd;
  end

  // A load in EX whose destination is read by the instruction in ID
  always_comb begin
    load_use_hazard = ex_memread && (ex_dest != '0) &&
                      ((ex_dest == id_rs) || (ex_dest == id_rt));
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus sequences for reset, stall, flush and hazards.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_aluop;
  logic [5:0]  id_funct;
  logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_dataA, alu_dataB, ex_store_data;
  logic [2:0]  alu_signal;
  logic [4:0]  ex_dest;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal, load_use_hazard;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_aluop(id_aluop), .id_funct(id_funct),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_signal(alu_signal),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_illegal(ex_illegal), .load_use_hazard(load_use_hazard)
  );

  // ctl = {alusrc, regdst, regwrite, memread, memwrite, memtoreg}
  // ectl = {regwrite, memread, memwrite, memtoreg}
  typedef struct packed {
    logic [31:0] rs_data; logic [31:0] rt_data; logic [15:0] imm;
    logic [4:0] rs; logic [4:0] rt; logic [4:0] rd;
    logic [1:0] aluop; logic [5:0] funct; logic [5:0] ctl;
    logic exw; logic [4:0] exrd; logic [31:0] exres;
    logic mww; logic [4:0] mwrd; logic [31:0] mwres;
    logic [31:0] ea; logic [31:0] eb; logic [31:0] esd;
    logic [2:0] esig; logic eill; logic [4:0] edest; logic [3:0] ectl;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_aluop = v.aluop; id_funct = v.funct;
    {id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg} = v.ctl;
    exmem_regwrite = v.exw; exmem_rd = v.exrd; exmem_result = v.exres;
    memwb_regwrite = v.mww; memwb_rd = v.mwrd; memwb_result = v.mwres;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    check({tag, ".dataA"}, alu_dataA, v.ea);
    check({tag, ".dataB"}, alu_dataB, v.eb);
    check({tag, ".store"}, ex_store_data, v.esd);
    check({tag, ".sig"}, {29'd0, alu_signal}, {29'd0, v.esig});
    check({tag, ".illegal"}, {31'd0, ex_illegal}, {31'd0, v.eill});
    check({tag, ".dest"}, {27'd0, ex_dest}, {27'd0, v.edest});
    check({tag, ".ctl"}, {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}, {28'd0, v.ectl});
  endtask

  task automatic randomize_id();
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = 16'($urandom);
    id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
    id_aluop = 2'($urandom); id_funct = 6'($urandom);
    {id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg} = 6'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              rs_data  rt_data  imm       rs    rt    rd    aop    funct       ctl        exw  exrd  exres     mww  mwrd  mwres     ea       eb            esd           sig     ill   dest  ectl
    vecs[0]  = '{32'd5,  32'd7,  16'h0000, 5'd1, 5'd2, 5'd3, 2'b00, 6'b000000, 6'b011000, 1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 32'd0,    32'd5,   32'd7,        32'd7,        3'b010, 1'b0, 5'd3, 4'b1000};
    vecs[1]  = '{32'd5,  32'd7,  16'hFFFE, 5'd1, 5'd2, 5'd3, 2'b01, 6'b000000, 6'b111000, 1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 32'd0,    32'd5,   32'hFFFFFFFE, 32'd7,        3'b110, 1'b0, 5'd3, 4'b1000};
    vecs[2]  = '{32'd11, 32'd22, 16'h0000, 5'd3, 5'd2, 5'd3, 2'b10, 6'b100100, 6'b011000, 1'b1, 5'd3, 32'd100,  1'b1, 5'd3, 32'd200,  32'd100, 32'd22,       32'd22,       3'b000, 1'b0, 5'd3, 4'b1000};
    vecs[3]  = '{32'd11, 32'd22, 16'h0000, 5'd3, 5'd2, 5'd3, 2'b10, 6'b100101, 6'b011000, 1'b0, 5'd3, 32'd100,  1'b1, 5'd3, 32'd200,  32'd200, 32'd22,       32'd22,       3'b001, 1'b0, 5'd3, 4'b1000};
    vecs[4]  = '{32'd11, 32'd22, 16'h0000, 5'd3, 5'd2, 5'd3, 2'b10, 6'b100010, 6'b011000, 1'b1, 5'd0, 32'd100,  1'b1, 5'd0, 32'd200,  32'd11,  32'd22,       32'd22,       3'b110, 1'b0, 5'd3, 4'b1000};
    vecs[5]  = '{32'd4,  32'd1,  16'h0000, 5'd5, 5'd6, 5'd7, 2'b10, 6'b100000, 6'b011000, 1'b1, 5'd9, 32'h77,   1'b1, 5'd6, 32'hDEAD, 32'd4,   32'hDEAD,     32'hDEAD,     3'b010, 1'b0, 5'd7, 4'b1000};
    vecs[6]  = '{32'd4,  32'd1,  16'h0010, 5'd5, 5'd6, 5'd7, 2'b00, 6'b000000, 6'b100010, 1'b1, 5'd9, 32'h77,   1'b1, 5'd6, 32'hDEAD, 32'd4,   32'h10,       32'hDEAD,     3'b010, 1'b0, 5'd6, 4'b0010};
    vecs[7]  = '{32'h55, 32'h66, 16'h8000, 5'd0, 5'd4, 5'd8, 2'b11, 6'b000000, 6'b101101, 1'b1, 5'd0, 32'h99,   1'b1, 5'd0, 32'hAA,   32'h55,  32'hFFFF8000, 32'h66,       3'b010, 1'b1, 5'd4, 4'b1101};
    vecs[8]  = '{32'd1,  32'd2,  16'h0000, 5'd1, 5'd2, 5'd3, 2'b10, 6'b000000, 6'b011000, 1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 32'd0,    32'd1,   32'd2,        32'd2,        3'b010, 1'b1, 5'd3, 4'b1000};
    vecs[9]  = '{32'd1,  32'd2,  16'h0000, 5'd1, 5'd2, 5'd3, 2'b01, 6'b000000, 6'b011000, 1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 32'd0,    32'd1,   32'd2,        32'd2,        3'b110, 1'b0, 5'd3, 4'b1000};
    vecs[10] = '{32'd1,  32'd2,  16'h0000, 5'd1, 5'd2, 5'd3, 2'b10, 6'b101010, 6'b011000, 1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 32'd0,    32'd1,   32'd2,        32'd2,        3'b111, 1'b0, 5'd3, 4'b1000};
    vecs[11] = '{32'd4,  32'd1,  16'h0000, 5'd5, 5'd6, 5'd7, 2'b00, 6'b000000, 6'b011000, 1'b1, 5'd6, 32'h123,  1'b1, 5'd6, 32'hDEAD, 32'd4,   32'h123,      32'h123,      3'b010, 1'b0, 5'd7, 4'b1000};

    // Reset with random inputs: everything reads as zero
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    randomize_id();
    exmem_regwrite = 1'b1; exmem_rd = 5'($urandom); exmem_result = $urandom;
    memwb_regwrite = 1'b1; memwb_rd = 5'($urandom); memwb_result = $urandom;
    tick();
    randomize_id();
    tick();
    check("rst.dataA", alu_dataA, 32'd0);
    check("rst.dataB", alu_dataB, 32'd0);
    check("rst.store", ex_store_data, 32'd0);
    check("rst.sig", {29'd0, alu_signal}, 32'd0);
    check("rst.dest", {27'd0, ex_dest}, 32'd0);
    check("rst.ctl", {27'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal}, 32'd0);
    check("rst.hazard", {31'd0, load_use_hazard}, 32'd0);

    // First capture after reset release: SLT
    reset = 1'b1;
    drive(vecs[10]);
    tick();
    check("slt.sig", {29'd0, alu_signal}, 32'd7);
    check("slt.illegal", {31'd0, ex_illegal}, 32'd0);

    // Table-driven vectors, one-cycle capture each
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      tick();
      check_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Load-use: load into rt=4 in EX, then the next ID reads r4
    drive(vecs[7]);
    tick();
    id_rs = 5'd4; id_rt = 5'd0;
    #1 check("hz.rs_match", {31'd0, load_use_hazard}, 32'd1);
    id_rs = 5'd0; id_rt = 5'd4;
    #1 check("hz.rt_match", {31'd0, load_use_hazard}, 32'd1);
    id_rs = 5'd0; id_rt = 5'd0;
    #1 check("hz.no_match", {31'd0, load_use_hazard}, 32'd0);
    // Load with destination 0 never raises a hazard
    id_rt = 5'd0; id_rs = 5'd0; id_regdst = 1'b0; id_memread = 1'b1;
    tick();
    check("hz.dest0", {31'd0, load_use_hazard}, 32'd0);
    // Non-load writer matching the ID source is handled by forwarding, not a hazard
    drive(vecs[0]);
    tick();
    id_rs = 5'd3;
    #1 check("hz.not_load", {31'd0, load_use_hazard}, 32'd0);

    // Stall holds everything for three cycles while ID changes
    drive(vecs[2]);
    tick();
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      randomize_id();
      tick();
      check_vec(vecs[2], $sformatf("stall%0d", c));
    end
    // Flush together with stall still inserts a bubble
    flush = 1'b1;
    tick();
    check("sflush.ctl", {27'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal}, 32'd0);
    check("sflush.sig", {29'd0, alu_signal}, 32'd0);
    check("sflush.dest", {27'd0, ex_dest}, 32'd0);
    check("sflush.dataA", alu_dataA, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Flush alone after a normal capture
    drive(vecs[7]);
    tick();
    check_vec(vecs[7], "pre_flush");
    flush = 1'b1;
    tick();
    check("flush.ctl", {27'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal}, 32'd0);
    flush = 1'b0;

    // Reset mid-operation behaves as a bubble
    drive(vecs[6]);
    tick();
    check_vec(vecs[6], "pre_rst");
    reset = 1'b0;
    drive(vecs[0]);
    tick();
    check("midrst.ctl", {27'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal}, 32'd0);
    check("midrst.sig", {29'd0, alu_signal}, 32'd0);
    check("midrst.dest", {27'd0, ex_dest}, 32'd0);
    reset = 1'b1;
    tick();
    check_vec(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register of the 5-stage CPU, sitting directly upstream of the 32-bit ALU. It latches decoded operands and control signals, and decodes ALUOp/funct into the 3-bit ALU Signal. It forwards EX/MEM and MEM/WB results into the ALU operands dataA/dataB. It also detects load-use hazards and supports stall (hold) and flush (bubble insertion).

Parameters:
DW, 32, datapath width
RW, 5, register index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
stall  in  1  hold all ID/EX contents
flush  in  1  load bubble (all control zero) on next edge
id_rs_data  in  DW  register file read port A
id_rt_data  in  DW  register file read port B
id_imm  in  16  immediate field
id_rs, id_rt, id_rd  in  RW  register indices
id_aluop  in  2  00 add, 01 sub, 10 R-type
id_funct  in  6  instruction funct field
id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  control bits
exmem_regwrite  in  1  EX/MEM write enable
exmem_rd  in  RW  EX/MEM destination
exmem_result  in  DW  EX/MEM ALU result
memwb_regwrite  in  1  MEM/WB write enable
memwb_rd  in  RW  MEM/WB destination
memwb_result  in  DW  MEM/WB writeback value
alu_dataA, alu_dataB  out  DW  ALU operands (combinational from registered state plus forwarding)
alu_signal  out  3  ALU function code (registered)
ex_store_data  out  DW  forwarded rt value for stores
ex_dest  out  RW  selected destination (rd if regdst, else rt)
ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each  registered control
ex_illegal  out  1  registered flag: unsupported funct
load_use_hazard  out  1  combinational: stall request to IF/ID

Behaviour:
- All state updates on rising clk. reset low => every register is 0, so alu_signal=000 (AND), all control=0, ex_dest=0, ex_illegal=0. reset has priority over flush, and flush has priority over stall.
- flush (reset high): control bits, ex_illegal and alu_signal are set to 0; data/index registers are don't-care but must also be zeroed. A flush asserted while stall is also high is still applied.
- stall (no flush): all registers hold their values.
- Otherwise: capture all id_* values. Latency is exactly 1 cycle from ID inputs to EX outputs.
- Immediate: sign-extended to DW at capture.
- ALU Signal decode: aluop 00 -> 010; aluop 01 -> 110; aluop 11 -> 010 with ex_illegal=1.
- aluop 10 decodes funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111. Any other funct gives 010 with ex_illegal=1.
- Forward select per source (rs, rt):
  - Use EX/MEM when exmem_regwrite, exmem_rd!=0 and exmem_rd equals the index.
  - Otherwise use MEM/WB under the same conditions with memwb_*.
  - Otherwise use the registered read data.
  - EX/MEM wins when both stages match.
  - A register index of 0 never forwards.
- Operand mapping: alu_dataA = forwarded rs. alu_dataB = sign-extended imm if alusrc, else forwarded rt. ex_store_data = forwarded rt, always.
- load_use_hazard = ex_memread & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt). The block does not self-stall; the hazard unit turns this into stall of IF/ID plus flush here.
- Reset mid-operation: the next cycle shows a bubble, identical to flush.

Decomposition:
- Shared package (cpu_defs): ALU codes AND/OR/ADD/SUB/SLT, ALUOp codes, funct constants, forward-select enum (REG, EXMEM, MEMWB).
- One sub-module: fwd_unit, purely combinational, computing the rs/rt forward selects. The registers, the ALU decode and the operand muxes stay in the top module.

Test Plan:
1. reset low for 2 cycles with random inputs -> all outputs 0, alu_signal=000; then reset high, aluop=10, funct=101010 -> next cycle alu_signal=111, ex_illegal=0.
2. Capture rs_data=5, rt_data=7, alusrc=0, no matching forward -> alu_dataA=5, alu_dataB=7. Then alusrc=1, imm=16'hFFFE -> alu_dataB=32'hFFFFFFFE.
3. Registered rs=3; exmem_rd=3 with result 100 and memwb_rd=3 with result 200, both regwrite=1 -> alu_dataA=100. Drop exmem_regwrite -> 200. Set both rd=0 -> original reg data.
4. Captured memread=1, rt=4 as dest (regdst=0); next ID has id_rs=4 -> load_use_hazard=1. With id_rs=id_rt=0 and dest 0 -> load_use_hazard=0.
5. stall=1 for 3 cycles while id_* changes -> outputs unchanged. stall=1 and flush=1 together -> control zero next cycle.
6. aluop=10, funct=000000 -> alu_signal=010, ex_illegal=1. aluop=01 -> alu_signal=110, ex_illegal=0.
